// File: rtl/keypad_scan_debounce.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce for 16 keys
// plus the encoder push-switch; emits one-clock strobes on debounced presses.
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned DEBOUNCE_FRAMES = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  input  logic        encoder_sw,
  output logic [15:0] key_pulse,
  output logic [15:0] key_state,
  output logic        encoder_press
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam int unsigned NCH   = 17;

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_e;

  col_e             col, col_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic             sample;
  logic             frame_end;
  logic             frame_end_q;

  logic [3:0]       row_s1, row_s2;
  logic             enc_s1, enc_s2;

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   stable;
  logic [NCH-1:0]   pulse;
  logic [3:0]       cnt [NCH];

  // Synchronisers idle at 1 (released) so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
      enc_s1 <= 1'b1;
      enc_s2 <= 1'b1;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      enc_s1 <= encoder_sw;
      enc_s2 <= enc_s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= COL0;
      div <= '0;
    end else begin
      col <= col_nxt;
      div <= div_nxt;
    end
  end

  always_comb begin
    sample    = (div == DIV_W'(SCAN_DIV - 1));
    frame_end = sample && (col == COL3);
    div_nxt   = div + 1'b1;
    col_nxt   = col;
    if (sample) begin
      div_nxt = '0;
      unique case (col)
        COL0:    col_nxt = COL1;
        COL1:    col_nxt = COL2;
        COL2:    col_nxt = COL3;
        default: col_nxt = COL0;
      endcase
    end
  end

  always_comb begin
    unique case (col)
      COL0:    col_out = 4'b1110;
      COL1:    col_out = 4'b1101;
      COL2:    col_out = 4'b1011;
      default: col_out = 4'b0111;
    endcase
  end

  // Raw snapshot: one column of keys per sample cycle, encoder at frame end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw         <= '0;
      frame_end_q <= 1'b0;
    end else begin
      frame_end_q <= frame_end;
      if (sample) begin
        for (int unsigned r = 0; r < 4; r++) begin
          raw[5'(4 * r) + {3'b000, col}] <= ~row_s2[r];
        end
      end
      if (frame_end) begin
        raw[16] <= ~enc_s2;
      end
    end
  end

  // Debounce runs a cycle after frame end so the last column is in raw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      pulse  <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      pulse <= '0;
      if (frame_end_q) begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (raw[i] == stable[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] == 4'(DEBOUNCE_FRAMES - 1)) begin
            cnt[i]    <= '0;
            stable[i] <= raw[i];
            pulse[i]  <= raw[i];
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  assign key_state     = stable[15:0];
  assign key_pulse     = pulse[15:0];
  assign encoder_press = pulse[16];

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_FRAMES=3.
`timescale 1ns/1ps
module tb_keypad_scan_debounce;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic        encoder_sw;
  logic [15:0] key_pulse;
  logic [15:0] key_state;
  logic        encoder_press;

  logic [15:0] keys;
  logic        keep_log;
  int          cyc;
  int          pulse_cnt [17];
  int          last_cyc  [17];
  int          checks = 0;
  int          errors = 0;

  keypad_scan_debounce #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .row_in        (row_in),
    .col_out       (col_out),
    .encoder_sw    (encoder_sw),
    .key_pulse     (key_pulse),
    .key_state     (key_state),
    .encoder_press (encoder_press)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Clock count since last reset release: after posedge n, cyc == n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n && !keep_log) begin
      for (int k = 0; k < 17; k++) begin
        pulse_cnt[k] <= 0;
        last_cyc[k]  <= -1;
      end
    end else begin
      for (int k = 0; k < 16; k++)
        if (key_pulse[k]) begin
          pulse_cnt[k] <= pulse_cnt[k] + 1;
          last_cyc[k]  <= cyc;
        end
      if (encoder_press) begin
        pulse_cnt[16] <= pulse_cnt[16] + 1;
        last_cyc[16]  <= cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] k, input logic enc);
    keep_log   = 1'b0;
    rst_n      = 1'b0;
    keys       = k;
    encoder_sw = enc;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_col;
    int         total;

    keep_log   = 1'b0;
    rst_n      = 1'b0;
    keys       = '0;
    encoder_sw = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_col_out", 32'(col_out), 32'hE);
    check_eq("rst_key_state", 32'(key_state), 32'h0);
    check_eq("rst_key_pulse", 32'(key_pulse), 32'h0);
    check_eq("rst_enc_press", 32'(encoder_press), 32'h0);

    // Idle scan: column walks every 4 clocks, outputs stay quiet for 10 frames.
    do_reset(16'h0000, 1'b1);
    for (int e = 1; e <= 160; e++) begin
      wait_cyc(e);
      exp_col = ~(4'b0001 << ((e / 4) % 4));
      check_eq("scan_col_out", 32'(col_out), 32'(exp_col));
    end
    total = 0;
    for (int k = 0; k < 17; k++) total += pulse_cnt[k];
    check_eq("scan_no_pulse", total, 0);
    check_eq("scan_key_state", 32'(key_state), 32'h0);

    // Clean press of key 5 held from reset; flip at clock 49, release at 100.
    do_reset(16'h0020, 1'b1);
    wait_cyc(48);
    check_eq("press_pre_state", 32'(key_state), 32'h0);
    check_eq("press_pre_pulse", 32'(key_pulse), 32'h0);
    wait_cyc(49);
    check_eq("press_pulse", 32'(key_pulse), 32'h0020);
    check_eq("press_state", 32'(key_state), 32'h0020);
    wait_cyc(50);
    check_eq("press_pulse_drop", 32'(key_pulse), 32'h0);
    wait_cyc(100);
    check_eq("press_held_cnt", pulse_cnt[5], 1);
    check_eq("press_pulse_cyc", last_cyc[5], 49);
    keys = '0;
    wait_cyc(144);
    check_eq("release_pre_state", 32'(key_state), 32'h0020);
    wait_cyc(145);
    check_eq("release_state", 32'(key_state), 32'h0);
    wait_cyc(160);
    check_eq("release_no_pulse", pulse_cnt[5], 1);

    // Bounce: 2 frames pressed, 1 released, five times.
    do_reset(16'h0020, 1'b1);
    for (int m = 1; m < 15; m++) begin
      wait_cyc(16 * m);
      keys = (m % 3 != 2) ? 16'h0020 : 16'h0000;
      check_eq("bounce_state", 32'(key_state), 32'h0);
    end
    wait_cyc(16 * 15);
    keys = '0;
    wait_cyc(16 * 19);
    check_eq("bounce_no_pulse", pulse_cnt[5], 0);
    check_eq("bounce_state_end", 32'(key_state), 32'h0);

    // Keys 0 and 15 pressed together at the start of frame 2.
    do_reset(16'h0000, 1'b1);
    wait_cyc(16);
    keys = 16'h8001;
    wait_cyc(64);
    check_eq("simul_pre_pulse", 32'(key_pulse), 32'h0);
    wait_cyc(65);
    check_eq("simul_pulse", 32'(key_pulse), 32'h8001);
    check_eq("simul_enc_quiet", 32'(encoder_press), 32'h0);
    wait_cyc(66);
    check_eq("simul_pulse_drop", 32'(key_pulse), 32'h0);
    check_eq("simul_state", 32'(key_state), 32'h8001);
    wait_cyc(80);
    check_eq("simul_cnt0", pulse_cnt[0], 1);
    check_eq("simul_cnt15", pulse_cnt[15], 1);
    total = 0;
    for (int k = 1; k < 15; k++) total += pulse_cnt[k];
    check_eq("simul_others", total, 0);

    // Encoder held from reset, released, then a one-frame glitch.
    do_reset(16'h0000, 1'b0);
    wait_cyc(48);
    check_eq("enc_pre_press", 32'(encoder_press), 32'h0);
    wait_cyc(49);
    check_eq("enc_press", 32'(encoder_press), 32'h1);
    wait_cyc(50);
    check_eq("enc_press_drop", 32'(encoder_press), 32'h0);
    wait_cyc(60);
    encoder_sw = 1'b1;
    wait_cyc(100);
    encoder_sw = 1'b0;
    wait_cyc(116);
    encoder_sw = 1'b1;
    wait_cyc(200);
    check_eq("enc_glitch_cnt", pulse_cnt[16], 1);
    check_eq("enc_press_cyc", last_cyc[16], 49);
    total = 0;
    for (int k = 0; k < 16; k++) total += pulse_cnt[k];
    check_eq("enc_no_key_pulse", total, 0);

    // Reset asserted mid-debounce while key 10 is held.
    do_reset(16'h0400, 1'b1);
    wait_cyc(36);
    check_eq("mid_pre_state", 32'(key_state), 32'h0);
    keep_log = 1'b1;
    rst_n    = 1'b0;
    #1;
    check_eq("mid_rst_col", 32'(col_out), 32'hE);
    check_eq("mid_rst_state", 32'(key_state), 32'h0);
    check_eq("mid_rst_pulse", 32'(key_pulse), 32'h0);
    check_eq("mid_rst_enc", 32'(encoder_press), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    check_eq("mid_rst_col_hold", 32'(col_out), 32'hE);
    rst_n = 1'b1;
    wait_cyc(48);
    check_eq("mid_no_early_pulse", pulse_cnt[10], 0);
    wait_cyc(49);
    check_eq("mid_pulse", 32'(key_pulse), 32'h0400);
    wait_cyc(60);
    check_eq("mid_pulse_cnt", pulse_cnt[10], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_debounce.md
# keypad_scan_debounce

Front-end input block that produces the one-cycle `key_pulse[15:0]` and `encoder_press` strobes consumed by the mode controller. It scans a 4x4 active-low matrix keypad by driving one column low at a time. Each key and the encoder push-switch are debounced over whole scan frames, and the block emits a single-clock pulse on each debounced press. It sits between the board pins and the mode controller, in the same clock domain.

## Interface
- `SCAN_DIV`, default 50000: clocks per column period. Legal range is >= 4. The default gives 1 ms at 50 MHz.
- `DEBOUNCE_FRAMES`, default 5: number of consecutive frames a raw level must differ from the stable level before the stable level flips. Legal range is 1..15.
- `clk`  in  1: system clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `row_in`  in  4: keypad rows, asynchronous, active-low, externally pulled up.
- `col_out`  out  4: keypad column drive, active-low, exactly one bit low at all times.
- `encoder_sw`  in  1: raw encoder push-switch, asynchronous, active-low.
- `key_pulse`  out  16: one-clock strobe per debounced key press.
- `key_state`  out  16: debounced level, 1 = held.
- `encoder_press`  out  1: one-clock strobe per debounced encoder press.

## Operation
- **Synchronisers:** `row_in` and `encoder_sw` each pass through a 2-FF synchroniser. All logic uses only the synchronised values.
- **Key index:** `k = row*4 + col`. Key (r,c) reads pressed when `col_out[c]=0` and the synchronised `row[r]=0`.
- **Scan FSM:** a column index `col` (0..3) and a divider counter `div` (0..SCAN_DIV-1).
  - `col_out = ~(4'b0001 << col)`.
  - `div` counts up each clock. When `div == SCAN_DIV-1` it is the sample cycle.
  - On the sample cycle, the 4 inverted synchronised rows are captured into raw snapshot bits `{k | k%4 == col}`. `div` then returns to 0 and `col` increments, wrapping 3 -> 0.
- **Frame end:** the sample cycle with `col == 3`. On that cycle the synchronised encoder level (inverted) is also captured as raw bit 16.
- **Debounce:** runs one step per frame end, after that frame's snapshot is complete. It covers 17 channels (16 keys plus the encoder), each with a 4-bit counter `cnt`.
  - If raw == stable, `cnt` is set to 0.
  - Otherwise `cnt` increments. When it reaches `DEBOUNCE_FRAMES`, stable flips and `cnt` is set to 0.
  - A flip 0 -> 1 raises that channel's pulse. A flip 1 -> 0 raises no pulse.
- **Outputs:** `key_state` is stable[15:0]. `key_pulse[k]` is high for exactly one clock per 0 -> 1 flip. `encoder_press` is the pulse for channel 16.
- **Simultaneous events:** any number of channels may flip on the same debounce step, and all of their pulses assert in the same clock.
- **Ghosting:** not handled. With 3 or more keys held, phantom keys may register.

## Timing
- **Reset values:**
  - `col_out` = 4'b1110, `col` = 0, `div` = 0.
  - All `cnt`, raw and stable bits are 0.
  - `key_state` = 0, `key_pulse` = 0, `encoder_press` = 0.
  - Synchroniser flops are 1, meaning released.
- **Input latency:** the synchroniser adds 2 clocks. Rows seen on a sample cycle reflect pins 2 clocks earlier. Columns change on the clock after the sample cycle, so `SCAN_DIV >= 4` guarantees at least 2 settle clocks.
- **Frame length:** 4*SCAN_DIV clocks.
- **Debounce step timing:** the debounce uses a registered frame-end flag, so the debounce step and the pulses register on the clock after the frame-end sample cycle. Pulses drop on the following clock.
- **Press-to-pulse latency:** for a clean press, the pulse comes at the end of the `DEBOUNCE_FRAMES`-th frame that reads pressed. `key_state` rises in the same clock as the pulse.
- **Bounce rejection:** any frame that reads equal to stable restarts the count, so glitches shorter than `DEBOUNCE_FRAMES` consecutive frames are ignored.
- **Reset mid-operation:** all state is cleared immediately, and no pulse is emitted during or on exit from reset. A key held through reset is treated as a new press and pulses `DEBOUNCE_FRAMES` frames after reset release.

## Test plan
Bench parameters are `SCAN_DIV=4`, `DEBOUNCE_FRAMES=3` (16-clock frame). The keypad model pulls `row[r]` low while `col_out[c]=0` and key (r,c) is pressed.

- **Scan pattern:** idle, no keys pressed -> `col_out` cycles 1110, 1101, 1011, 0111, each for 4 clocks and wrapping. `key_pulse`, `key_state` and `encoder_press` stay 0 for 10 frames.
- **Clean press and release:** hold key 5 (row 1, col 1) from clock 0 -> `key_pulse[5]` is high for exactly 1 clock after the 3rd frame end. `key_state[5]` is then 1, and there is no second pulse while held. Release -> `key_state[5]` falls 3 frames later, with no pulse.
- **Bounce:** key 5 alternates pressed for 2 frames and released for 1 frame, 5 times -> no pulse, `key_state[5]` stays 0.
- **Simultaneous keys:** keys 0 and 15 pressed in the same clock -> `key_pulse[0]` and `key_pulse[15]` are high in the same single clock, and no other bit is set.
- **Encoder switch:** `encoder_sw` held low -> one-clock `encoder_press` after 3 frames. A 1-frame low glitch produces no pulse.
- **Reset mid-debounce:** key 10 held, `rst_n` pulsed low after 2 frames -> outputs are 0 and `col_out` is 1110 within the reset. There is no pulse at release, and `key_pulse[10]` fires 3 frames after release.
